// File: rtl/lc4_divider_iter.sv
// Restoring unsigned divider (DIV/MOD) for the LC4 ALU, one quotient bit per cycle.
// Optional early-exit path for zero divisor or dividend < divisor: LC4_DIV_FASTPATH_EN.
module lc4_divider_iter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            r_state;
    logic [WIDTH-1:0]  r_shift;
    logic [WIDTH-1:0]  r_div;
    logic [WIDTH-1:0]  r_rem;
    logic [CntW-1:0]   r_cnt;

    logic [WIDTH:0]    w_shifted;
    logic [WIDTH-1:0]  w_div_n;
    logic [WIDTH-1:0]  w_sum;
    logic              w_c16;
    logic              w_neg;
    logic [WIDTH-1:0]  w_rem_next;
    logic [WIDTH-1:0]  w_shift_next;

    // 16-bit carry-lookahead adder: 4-bit groups with a lookahead carry chain between groups.
    function automatic logic [15:0] cla16(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] c;
        logic [3:0]  gg;
        logic [3:0]  gp;
        logic [3:0]  gc;
        g = a & b;
        p = a ^ b;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        gc[0] = cin;
        for (int k = 0; k < 3; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
        return p ^ c;
    endfunction

    assign w_shifted = {r_rem, r_shift[WIDTH-1]};
    assign w_div_n   = ~r_div;
    assign w_sum     = cla16(w_shifted[WIDTH-1:0], w_div_n, 1'b1);

    // Carry out of bit 15 recovered from the sum bit; bit 16 of the trial result is the sign.
    assign w_c16 = (w_shifted[WIDTH-1] & w_div_n[WIDTH-1])
                 | (w_shifted[WIDTH-1] & (w_sum[WIDTH-1] ^ w_shifted[WIDTH-1] ^ w_div_n[WIDTH-1]))
                 | (w_div_n[WIDTH-1] & (w_sum[WIDTH-1] ^ w_shifted[WIDTH-1] ^ w_div_n[WIDTH-1]));
    assign w_neg = w_shifted[WIDTH] ^ 1'b1 ^ w_c16;

    assign w_rem_next   = w_neg ? w_shifted[WIDTH-1:0] : w_sum;
    assign w_shift_next = {r_shift[WIDTH-2:0], ~w_neg};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_div       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            o_ready     <= 1'b1;
            o_valid     <= 1'b0;
            o_quotient  <= '0;
            o_remainder <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_valid) begin
                        r_shift <= i_dividend;
                        r_div   <= i_divisor;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        o_ready <= 1'b0;
`ifdef LC4_DIV_FASTPATH_EN
                        if ((i_divisor == '0) || (i_dividend < i_divisor)) begin
                            r_state     <= StDone;
                            o_valid     <= 1'b1;
                            o_quotient  <= '0;
                            o_remainder <= (i_divisor == '0) ? '0 : i_dividend;
                        end else begin
                            r_state <= StRun;
                        end
`else
                        r_state <= StRun;
`endif
                    end
                end
                StRun: begin
                    r_rem   <= w_rem_next;
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CntW'(WIDTH - 1)) begin
                        r_state <= StDone;
                        o_valid <= 1'b1;
                        // LC4 defines x/0 and x%0 as zero.
                        if (r_div == '0) begin
                            o_quotient  <= '0;
                            o_remainder <= '0;
                        end else begin
                            o_quotient  <= w_shift_next;
                            o_remainder <= w_rem_next;
                        end
                    end
                end
                StDone: begin
                    if (i_ready) begin
                        r_state <= StIdle;
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc4_divider_iter.sv
// Scoreboard bench for lc4_divider_iter: directed requests, latency, backpressure and reset abort.
module tb_lc4_divider_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_dividend;
    logic [15:0] i_divisor;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_quotient;
    logic [15:0] o_remainder;

    lc4_divider_iter #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_quotient (o_quotient),
        .o_remainder(o_remainder)
    );

    always #5 clk = ~clk;

`ifdef LC4_DIV_FASTPATH_EN
    localparam int LatFast = 1;
`else
    localparam int LatFast = 17;
`endif
    localparam int LatFull = 17;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
    endtask

    // Monitor: compare whenever the DUT presents a result; pop on the handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (o_valid) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_valid");
                end else begin
                    exp_t e;
                    e = sb[0];
                    if (!prev_valid) chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    chk("quotient", {16'h0, o_quotient}, {16'h0, e.q});
                    chk("remainder", {16'h0, o_remainder}, {16'h0, e.r});
                    chk("ready_in_done", {31'h0, o_ready}, 32'h0);
                    if (i_ready) void'(sb.pop_front());
                end
            end
            prev_valid = o_valid;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [15:0] dd, input logic [15:0] dv, input logic [15:0] q,
                         input logic [15:0] r, input int lat);
        int   n = 0;
        exp_t e;
        while (!o_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            fail_now("accept_wait");
        end else begin
            i_valid    = 1'b1;
            i_dividend = dd;
            i_divisor  = dv;
            @(posedge clk); #1;
            e.q = q; e.r = r; e.lat = lat; e.acc = cyc;
            sb.push_back(e);
            i_valid = 1'b0;
        end
    endtask

    task automatic wait_drained();
        int n = 0;
        while ((sb.size() != 0 || !o_ready) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) fail_now("drain_wait");
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        i_valid    = 1'b0;
        i_ready    = 1'b1;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", {31'h0, o_ready}, 32'h1);
        chk("rst_valid", {31'h0, o_valid}, 32'h0);
        chk("rst_quot", {16'h0, o_quotient}, 32'h0);
        chk("rst_rem", {16'h0, o_remainder}, 32'h0);

        issue(16'd100, 16'd7, 16'd14, 16'd2, LatFull);
        issue(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, LatFull);
        issue(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, LatFull);
        issue(16'h1234, 16'h0000, 16'h0000, 16'h0000, LatFast);
        issue(16'h0000, 16'h0005, 16'h0000, 16'h0000, LatFast);
        issue(16'd5, 16'd9, 16'd0, 16'd5, LatFast);
        wait_drained();

        // Backpressure in DONE with noisy request inputs.
        i_ready = 1'b0;
        issue(16'hABCD, 16'h0100, 16'h00AB, 16'h00CD, LatFull);
        n = 0;
        while (!o_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) fail_now("done_wait");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            i_valid    = ~i_valid;
            i_dividend = 16'($urandom);
            i_divisor  = 16'($urandom);
            chk("bp_ready", {31'h0, o_ready}, 32'h0);
            chk("bp_valid", {31'h0, o_valid}, 32'h1);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", {31'h0, o_valid}, 32'h0);
        chk("release_ready", {31'h0, o_ready}, 32'h1);
        chk("hold_quot", {16'h0, o_quotient}, 32'h00AB);
        issue(16'd1000, 16'd10, 16'd100, 16'd0, LatFull);
        wait_drained();

        // Reset during RUN abandons the operation.
        i_valid    = 1'b1;
        i_dividend = 16'd40000;
        i_divisor  = 16'd3;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("run_busy", {31'h0, o_ready}, 32'h0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", {31'h0, o_ready}, 32'h1);
        chk("abort_valid", {31'h0, o_valid}, 32'h0);
        chk("abort_quot", {16'h0, o_quotient}, 32'h0);
        chk("abort_rem", {16'h0, o_remainder}, 32'h0);
        repeat (20) @(posedge clk);
        #1 chk("abort_idle", {31'h0, o_ready}, 32'h1);
        issue(16'd9, 16'd4, 16'd2, 16'd1, LatFull);
        wait_drained();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc4_divider_iter.md
Name: lc4_divider_iter

Overview:
- Sequential unsigned divider for the LC4 datapath. Computes DIV and MOD for the ALU's multi-cycle path.
- Sits directly downstream of the 16-bit carry-lookahead adder and consumes it. The trial subtraction in each iteration is one pass through cla16, with a = partial remainder, b = ~divisor, cin = 1.
- Produces one quotient bit per cycle using the restoring algorithm.
- Uses a valid/ready handshake on both the request side and the result side.

Parameters:
- WIDTH, 16, operand width in bits. Only the value 16 is supported when the cla16 instance is used.

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- i_valid  input  1  request valid.
- o_ready  output  1  divider can accept a request. High only in IDLE.
- i_dividend  input  WIDTH  dividend. Captured on accept.
- i_divisor  input  WIDTH  divisor. Captured on accept.
- o_valid  output  1  result valid. High only in DONE.
- i_ready  input  1  consumer accepts the result.
- o_quotient  output  WIDTH  quotient.
- o_remainder  output  WIDTH  remainder.

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous, active-high.
  - When rst is high at a rising edge: state becomes IDLE, o_ready=1, o_valid=0, o_quotient=0, o_remainder=0, all internal registers cleared.
  - Reset asserted mid-RUN or in DONE abandons the operation. No result is emitted.
- States:
  - IDLE: o_ready=1, o_valid=0.
  - RUN: o_ready=0, o_valid=0.
  - DONE: o_ready=0, o_valid=1.
- IDLE -> RUN: on an edge with i_valid & o_ready.
  - Latch dividend into the quotient/shift register and divisor into a holding register.
  - Clear the WIDTH+1-bit partial remainder.
  - Set iteration counter = 0.
- RUN, each cycle:
  - Shift the partial remainder left by 1, bringing in the MSB of the shift register.
  - Trial-subtract the divisor in WIDTH+1 bits.
  - Low 16 bits come from cla16. Bit 16 = r[16] ^ 1 ^ c16, where c16 = carry out of bit 15, recovered as maj(a[15], ~d[15], sum[15]^a[15]^~d[15]).
  - If the result is non-negative: keep it and shift in quotient bit 1. Otherwise: keep the shifted remainder and shift in 0.
  - Counter increments.
- RUN -> DONE: after exactly WIDTH RUN cycles (counter reaches WIDTH-1 on that edge).
- Latency: request accepted at edge t -> o_valid high in the cycle after edge t+WIDTH (17 edges for WIDTH=16).
- DONE:
  - o_quotient and o_remainder are held stable while o_valid=1 and i_ready=0. Backpressure is unbounded.
- DONE -> IDLE: on an edge with i_ready=1.
  - o_valid drops. o_ready rises the following cycle, so there is no same-cycle back-to-back accept.
  - Outputs keep their last value until the next DONE.
- Divide by zero: o_quotient=0 and o_remainder=0, matching LC4 DIV/MOD semantics. The raw restoring result is overridden when the latched divisor is 0.
- Input handling:
  - i_dividend and i_divisor changing after accept have no effect.
  - i_valid while busy is ignored, not queued.
  - i_ready outside DONE is ignored.
- Boundaries:
  - dividend=0 -> 0/0.
  - divisor=1 -> quotient=dividend, remainder=0.
  - dividend=0xFFFF with divisor=0xFFFF -> 1/0. This case exercises the bit-16 path.

Optional Feature:
- Macro: LC4_DIV_FASTPATH_EN.
- When defined: if the latched divisor is 0, or dividend < divisor (unsigned), the divider goes IDLE -> DONE directly on the edge after accept. o_valid is high one cycle after accept.
  - Divisor 0 -> quotient 0, remainder 0.
  - dividend < divisor -> quotient 0, remainder = dividend.
- When undefined: every request takes the full WIDTH RUN cycles. Results are identical.

Test Plan:
- Reset, then dividend=100 (0x0064), divisor=7 -> o_valid at accept+17 edges; quotient=14 (0x000E), remainder=2.
- dividend=0xFFFF, divisor=0xFFFF -> quotient=1, remainder=0. Then dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0.
- dividend=0x1234, divisor=0 -> quotient=0, remainder=0. With LC4_DIV_FASTPATH_EN, o_valid at accept+1. Without it, at accept+17.
- Hold i_ready=0 for 10 cycles in DONE; toggle i_valid and the operands meanwhile -> outputs stable, o_ready=0, no new accept. Assert i_ready -> IDLE next cycle, then accept a new request.
- Assert rst at RUN cycle 5 of 40000/3 -> IDLE with all outputs 0 next cycle, no o_valid. A new request 9/4 then yields quotient=2, remainder=1.
- dividend=5, divisor=9 -> quotient=0, remainder=5. Latency is 1 cycle with the fast path and 17 without.
